// File: rtl/mem_stage_if.sv
// EX/MEM-side inputs and MEM/WB-side outputs of the memory stage.
// The pipeline drives through master; the memory stage implements slave.
interface mem_stage_if;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUoutM;
    logic [2:0]  funct3M;
    logic [31:0] RdM;
    logic [31:0] inc_PCM;
    logic [31:0] rs2M;
    logic        StallW;
    logic        FlushW;

    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUoutW;
    logic [31:0] ReadDataW;
    logic [31:0] RdW;
    logic [31:0] inc_PCW;
    logic        MisalignW;

    modport master (
        output RegWriteM, ResultSrcM, MemWriteM, ALUoutM, funct3M, RdM, inc_PCM, rs2M,
               StallW, FlushW,
        input  RegWriteW, ResultSrcW, ALUoutW, ReadDataW, RdW, inc_PCW, MisalignW
    );

    modport slave (
        input  RegWriteM, ResultSrcM, MemWriteM, ALUoutM, funct3M, RdM, inc_PCM, rs2M,
               StallW, FlushW,
        output RegWriteW, ResultSrcW, ALUoutW, ReadDataW, RdW, inc_PCW, MisalignW
    );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory stage: byte-addressed little-endian data RAM with sized stores,
// extended loads, misalignment detection, and the MEM/WB pipeline register.
module mem_stage #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave bus
);
    localparam int WORDS = 1 << (ADDR_WIDTH - 2);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic [31:0] alu_out;
        logic [31:0] read_data;
        logic [31:0] rd;
        logic [31:0] inc_pc;
        logic        misalign;
    } wb_t;

    // Stored as 32-bit words with byte lanes; aligned accesses never span two words.
    logic [31:0] ram [WORDS];

    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [1:0]            byte_off;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;

    logic        is_load;
    logic        size_ok;
    logic        store_f3_ok;
    logic        misalign;
    logic        store_en;
    logic [3:0]  byte_en;
    logic [31:0] wr_data;
    logic [31:0] load_data;

    wb_t wb_d, wb_q;

    assign addr     = bus.ALUoutM[ADDR_WIDTH-1:0];
    assign word_idx = addr[ADDR_WIDTH-1:2];
    assign byte_off = addr[1:0];
    assign is_load  = (bus.ResultSrcM == 2'b01);

    assign rd_word = ram[word_idx];
    assign rd_byte = rd_word[{byte_off, 3'b000} +: 8];
    assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        size_ok     = 1'b1;
        store_f3_ok = 1'b0;
        byte_en     = 4'b0000;
        wr_data     = 32'h0;
        load_data   = 32'h0;

        case (bus.funct3M)
            F3_B: begin
                store_f3_ok = 1'b1;
                byte_en     = 4'b0001 << byte_off;
                wr_data     = {4{bus.rs2M[7:0]}};
                load_data   = {{24{rd_byte[7]}}, rd_byte};
            end
            F3_BU: begin
                load_data = {24'h0, rd_byte};
            end
            F3_H: begin
                size_ok     = ~addr[0];
                store_f3_ok = 1'b1;
                byte_en     = 4'b0011 << {addr[1], 1'b0};
                wr_data     = {2{bus.rs2M[15:0]}};
                load_data   = {{16{rd_half[15]}}, rd_half};
            end
            F3_HU: begin
                size_ok   = ~addr[0];
                load_data = {16'h0, rd_half};
            end
            F3_W: begin
                size_ok     = (addr[1:0] == 2'b00);
                store_f3_ok = 1'b1;
                byte_en     = 4'b1111;
                wr_data     = bus.rs2M;
                load_data   = rd_word;
            end
            default: ;
        endcase

        // A store with an unsupported size is flagged; a load with one just returns 0.
        misalign = (bus.MemWriteM && (!store_f3_ok || !size_ok)) || (is_load && !size_ok);
        store_en = bus.MemWriteM && !misalign;
    end

    // NOTE: the RAM has no reset; its contents survive rst and are undefined until written.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (store_en && byte_en[b]) begin
                ram[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    always_comb begin
        wb_d.reg_write  = bus.RegWriteM && !(is_load && misalign);
        wb_d.result_src = bus.ResultSrcM;
        wb_d.alu_out    = bus.ALUoutM;
        wb_d.read_data  = (is_load && misalign) ? 32'h0 : load_data;
        wb_d.rd         = bus.RdM;
        wb_d.inc_pc     = bus.inc_PCM;
        wb_d.misalign   = misalign;
    end

    // Flush beats stall so a bubble can be injected even while writeback is held.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignment so the register samples values from before the edge.
        if (rst) begin
            wb_q <= '0;
        end else if (bus.FlushW) begin
            wb_q <= '0;
        end else if (!bus.StallW) begin
            wb_q <= wb_d;
        end
    end

    assign bus.RegWriteW  = wb_q.reg_write;
    assign bus.ResultSrcW = wb_q.result_src;
    assign bus.ALUoutW    = wb_q.alu_out;
    assign bus.ReadDataW  = wb_q.read_data;
    assign bus.RdW        = wb_q.rd;
    assign bus.inc_PCW    = wb_q.inc_pc;
    assign bus.MisalignW  = wb_q.misalign;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written stall/flush/reset
// sequences, then random traffic checked against a byte-level memory model.
module tb_mem_stage;
    localparam logic [31:0] AMASK = 32'h0001_FFFF;

    logic clk;
    logic rst;
    mem_stage_if bus ();

    mem_stage #(.ADDR_WIDTH(17)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_rw;
        logic        exp_mis;
        logic        chk_rd;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] rd;
        logic [31:0] pc;
        logic        mis;
        logic        chk_rd;
    } w_t;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] mem_m [int unsigned];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_w(input string tag, input w_t e);
        check({tag, " RegWriteW"},  32'(bus.RegWriteW),  32'(e.rw));
        check({tag, " ResultSrcW"}, 32'(bus.ResultSrcW), 32'(e.rs));
        check({tag, " ALUoutW"},    bus.ALUoutW,         e.alu);
        check({tag, " RdW"},        bus.RdW,             e.rd);
        check({tag, " inc_PCW"},    bus.inc_PCW,         e.pc);
        check({tag, " MisalignW"},  32'(bus.MisalignW),  32'(e.mis));
        if (e.chk_rd) check({tag, " ReadDataW"}, bus.ReadDataW, e.rdata);
    endtask

    function automatic w_t zero_w();
        w_t z;
        z.rw = 0; z.rs = 0; z.alu = 0; z.rdata = 0; z.rd = 0; z.pc = 0; z.mis = 0; z.chk_rd = 1;
        return z;
    endfunction

    task automatic drive(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rd,
                         input logic [31:0] pc, input logic stall, input logic flush);
        bus.RegWriteM  = rw;
        bus.ResultSrcM = rs;
        bus.MemWriteM  = mw;
        bus.funct3M    = f3;
        bus.ALUoutM    = addr;
        bus.rs2M       = data;
        bus.RdM        = rd;
        bus.inc_PCM    = pc;
        bus.StallW     = stall;
        bus.FlushW     = flush;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                input logic mis);
        vec_t v;
        v.rw = 0; v.rs = 2'b00; v.mw = 1; v.f3 = f3; v.addr = a; v.data = d;
        v.exp_rd = 0; v.exp_rw = 0; v.exp_mis = mis; v.chk_rd = 0;
        return v;
    endfunction

    function automatic vec_t ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] x,
                                input logic rw, input logic mis);
        vec_t v;
        v.rw = 1; v.rs = 2'b01; v.mw = 0; v.f3 = f3; v.addr = a; v.data = 32'hA5A5_A5A5;
        v.exp_rd = x; v.exp_rw = rw; v.exp_mis = mis; v.chk_rd = 1;
        return v;
    endfunction

    // Reference model: memory as individual bytes, access width = 2**funct3[1:0] bytes.
    function automatic w_t model_capture(input logic rw, input logic [1:0] rs, input logic mw,
                                         input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rd, input logic [31:0] pc);
        w_t e;
        int unsigned a = addr & AMASK;
        int nb = 1 << f3[1:0];
        bit valid_st = (f3 < 3);
        bit valid_ld = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        bit aligned = ((a % nb) == 0);
        bit is_ld = (rs == 2'b01);
        bit mis = (mw && !(valid_st && aligned)) || (is_ld && valid_ld && !aligned);
        logic [31:0] v = 0;
        if (is_ld && valid_ld && aligned) begin
            for (int k = 0; k < nb; k++) v = v | (32'(mem_m[(a + k) & AMASK]) << (8 * k));
            if (!f3[2] && nb < 4) begin
                int sh = 32 - 8 * nb;
                v = 32'($signed(v << sh) >>> sh);
            end
        end
        e.rw = rw && !(is_ld && mis);
        e.rs = rs;
        e.alu = addr;
        e.rdata = (is_ld && mis) ? 32'h0 : v;
        e.rd = rd;
        e.pc = pc;
        e.mis = mis;
        e.chk_rd = is_ld;
        return e;
    endfunction

    task automatic model_store(input logic mw, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] data);
        int unsigned a = addr & AMASK;
        int nb = 1 << f3[1:0];
        if (mw && f3 < 3 && (a % nb) == 0) begin
            for (int k = 0; k < nb; k++) mem_m[(a + k) & AMASK] = data[8*k +: 8];
        end
    endtask

    vec_t tbl[$];

    initial begin
        w_t e;
        w_t exp_q;

        tbl.push_back(st(3'b010, 32'h100, 32'hDEAD_BEEF, 0));
        tbl.push_back(ld(3'b010, 32'h100, 32'hDEAD_BEEF, 1, 0));
        tbl.push_back(st(3'b010, 32'h100, 32'h80F1_7F80, 0));
        tbl.push_back(ld(3'b000, 32'h100, 32'hFFFF_FF80, 1, 0));
        tbl.push_back(ld(3'b100, 32'h100, 32'h0000_0080, 1, 0));
        tbl.push_back(ld(3'b001, 32'h102, 32'hFFFF_80F1, 1, 0));
        tbl.push_back(ld(3'b101, 32'h102, 32'h0000_80F1, 1, 0));
        tbl.push_back(st(3'b010, 32'h200, 32'h1122_3344, 0));
        tbl.push_back(st(3'b000, 32'h201, 32'h1234_56AA, 0));
        tbl.push_back(ld(3'b010, 32'h200, 32'h1122_AA44, 1, 0));
        tbl.push_back(st(3'b010, 32'h204, 32'hCAFE_F00D, 0));
        tbl.push_back(st(3'b010, 32'h202, 32'h5555_5555, 1));
        tbl.push_back(ld(3'b010, 32'h200, 32'h1122_AA44, 1, 0));
        tbl.push_back(ld(3'b010, 32'h204, 32'hCAFE_F00D, 1, 0));
        tbl.push_back(ld(3'b001, 32'h101, 32'h0, 0, 1));
        tbl.push_back(st(3'b001, 32'h203, 32'h6666_6666, 1));
        tbl.push_back(st(3'b011, 32'h200, 32'h7777_7777, 1));
        tbl.push_back(ld(3'b010, 32'h200, 32'h1122_AA44, 1, 0));
        tbl.push_back(ld(3'b010, 32'h204, 32'hCAFE_F00D, 1, 0));
        tbl.push_back(ld(3'b010, 32'h0002_0100, 32'h80F1_7F80, 1, 0));
        tbl.push_back(st(3'b010, 32'hFFFF_FFFC, 32'h0BAD_CAFE, 0));
        tbl.push_back(ld(3'b010, 32'h0001_FFFC, 32'h0BAD_CAFE, 1, 0));
        tbl.push_back(ld(3'b011, 32'h200, 32'h0, 1, 0));
        tbl.push_back(ld(3'b001, 32'h206, 32'hFFFF_CAFE, 1, 0));
        tbl.push_back(ld(3'b101, 32'h204, 32'h0000_F00D, 1, 0));
        tbl.push_back(ld(3'b000, 32'h207, 32'hFFFF_FFCA, 1, 0));
        tbl.push_back(ld(3'b010, 32'h202, 32'h0, 0, 1));
        tbl.push_back(st(3'b001, 32'h206, 32'h0000_BEEF, 0));
        tbl.push_back(ld(3'b010, 32'h204, 32'hBEEF_F00D, 1, 0));
        tbl.push_back(st(3'b000, 32'h203, 32'hFFFF_FF99, 0));
        tbl.push_back(ld(3'b010, 32'h200, 32'h9922_AA44, 1, 0));

        // Reset: outputs clear asynchronously, before any clock edge, and stay clear.
        rst = 1'b0;
        drive(1, 2'b10, 0, 3'b010, 32'h3333_3333, 32'h1, 32'h1F, 32'h44, 0, 0);
        #2 rst = 1'b1;
        #1 check_w("reset_async", zero_w());
        tick();
        tick();
        check_w("reset_held", zero_w());
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].rw, tbl[i].rs, tbl[i].mw, tbl[i].f3, tbl[i].addr, tbl[i].data,
                  32'(i + 1), 32'h400 + 32'(4 * i), 0, 0);
            tick();
            e.rw = tbl[i].exp_rw; e.rs = tbl[i].rs; e.alu = tbl[i].addr; e.rdata = tbl[i].exp_rd;
            e.rd = 32'(i + 1); e.pc = 32'h400 + 32'(4 * i); e.mis = tbl[i].exp_mis;
            e.chk_rd = tbl[i].chk_rd;
            check_w($sformatf("vec%0d", i), e);
        end

        // Stall holds W for 3 cycles; a store issued during the stall still lands.
        drive(1, 2'b00, 0, 3'b000, 32'h1234, 32'h0, 32'd5, 32'h88, 0, 0);
        tick();
        e.rw = 1; e.rs = 0; e.alu = 32'h1234; e.rdata = 0; e.rd = 5; e.pc = 32'h88; e.mis = 0;
        e.chk_rd = 0;
        check_w("stall_capture", e);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) drive(0, 2'b00, 1, 3'b010, 32'h300, 32'h0000_0077, 32'd9, 32'h99, 1, 0);
            else drive(1, 2'b10, 0, 3'b000, 32'hABCD + 32'(c), 32'h0, 32'd7, 32'h77, 1, 0);
            tick();
            check_w($sformatf("stall_hold%0d", c), e);
        end
        drive(1, 2'b01, 0, 3'b010, 32'h300, 32'h0, 32'd3, 32'h8C, 0, 0);
        tick();
        e.rs = 2'b01; e.alu = 32'h300; e.rdata = 32'h77; e.rd = 3; e.pc = 32'h8C; e.chk_rd = 1;
        check_w("store_in_stall", e);

        // Flush wins over stall.
        drive(1, 2'b01, 0, 3'b010, 32'h300, 32'h0, 32'd11, 32'h90, 1, 1);
        tick();
        check_w("flush_over_stall", zero_w());

        // Async reset pulse between edges; RAM survives and first capture follows deassertion.
        drive(1, 2'b01, 0, 3'b010, 32'h200, 32'h0, 32'd12, 32'h94, 0, 0);
        tick();
        e.rw = 1; e.rs = 2'b01; e.alu = 32'h200; e.rdata = 32'h9922_AA44; e.rd = 12; e.pc = 32'h94;
        e.mis = 0; e.chk_rd = 1;
        check_w("pre_reset", e);
        drive(1, 2'b01, 0, 3'b010, 32'h100, 32'h0, 32'd13, 32'h98, 0, 0);
        #2 rst = 1'b1;
        #1 check_w("reset_midcycle", zero_w());
        #2 rst = 1'b0;
        tick();
        e.alu = 32'h100; e.rdata = 32'h80F1_7F80; e.rd = 13; e.pc = 32'h98;
        check_w("after_reset_ram", e);

        // Reset and flush together.
        drive(1, 2'b01, 0, 3'b010, 32'h100, 32'h0, 32'd14, 32'h9C, 0, 1);
        rst = 1'b1;
        tick();
        check_w("reset_and_flush", zero_w());
        rst = 1'b0;

        // Random phase over a 64-byte window with random upper address bits.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a = ($urandom & 32'hFFFE_0000) | (32'h4000 + 32'(4 * i));
            logic [31:0] d = $urandom;
            e = model_capture(0, 2'b00, 1, 3'b010, a, 32'(i), 32'h0);
            model_store(1, 3'b010, a, d);
            drive(0, 2'b00, 1, 3'b010, a, d, 32'(i), 32'h0, 0, 0);
            tick();
            check_w($sformatf("init%0d", i), e);
        end
        exp_q = e;

        for (int i = 0; i < 300; i++) begin
            int kind = $urandom_range(0, 2);
            logic rw = $urandom_range(0, 1) == 1;
            logic [1:0] rs = 2'b00;
            logic mw = 0;
            logic [2:0] f3 = 3'($urandom_range(0, 7));
            logic [31:0] off = 32'($urandom_range(0, 63));
            logic [31:0] a, d, rd, pc;
            logic stall = $urandom_range(0, 9) == 0;
            logic flush = $urandom_range(0, 9) == 0;
            w_t cap;
            if ($urandom_range(0, 1) == 1) off = off & ~((32'd1 << f3[1:0]) - 1);
            if (f3[1:0] == 2'b10 && off > 60) off = 60;
            a = ($urandom & 32'hFFFE_0000) | (32'h4000 + off);
            d = $urandom;
            rd = $urandom;
            pc = $urandom;
            if (kind == 0) begin
                mw = 1; rw = 0;
                if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
            end else if (kind == 1) begin
                rw = 1; rs = 2'b01;
            end else begin
                rs = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
            end
            cap = model_capture(rw, rs, mw, f3, a, rd, pc);
            model_store(mw, f3, a, d);
            if (flush) exp_q = zero_w();
            else if (!stall) exp_q = cap;
            drive(rw, rs, mw, f3, a, d, rd, pc, stall, flush);
            tick();
            check_w($sformatf("rand%0d", i), exp_q);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
